icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache sitting directly downstream of the fetch stage.
- Takes the fetch PC and returns the instruction word in the same cycle on a hit.
- On a miss it raises stall_o, which drives the fetch stage's stall input, and refills a full line from instruction memory over a req/ready handshake.
- The instruction word feeds the decode stage.

---
 rtl/icache_dm.sv | 105 ++++++++++
 tb/tb_icache_dm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. A hit returns the word in the
// same cycle; a miss stalls fetch and refills one 128-bit line over req/ready.
module icache_dm #(
   parameter int          LINES      = 4,
   parameter int          LINE_WORDS = 4,
   parameter logic [31:0] NOP        = 32'h0000_0013
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [31:0]                pc_i,
   input  logic                       invalidate_i,
   output logic [31:0]                instr_o,
   output logic                       stall_o,
   output logic                       mem_req_o,
   output logic [31:0]                mem_addr_o,
   input  logic [LINE_WORDS*32-1:0]   mem_data_i,
   input  logic                       mem_ready_i
);

   localparam int IW     = $clog2(LINES);
   localparam int TW     = 28 - IW;
   localparam int LINE_W = LINE_WORDS * 32;

   typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

   state_t             state_q, state_d;
   logic [LINES-1:0]   valid_q, valid_d;
   logic [31:0]        miss_addr_q, miss_addr_d;
   logic [TW-1:0]      tag_q  [LINES];
   logic [LINE_W-1:0]  data_q [LINES];

   logic [IW-1:0]      pc_idx, miss_idx;
   logic [TW-1:0]      pc_tag, miss_tag;
   logic               hit, fill_we;
   logic               unused_pc_bits;

   assign pc_idx         = pc_i[3+IW:4];
   assign pc_tag         = pc_i[31:4+IW];
   assign miss_idx       = miss_addr_q[3+IW:4];
   assign miss_tag       = miss_addr_q[31:4+IW];
   assign unused_pc_bits = ^pc_i[1:0];

   assign hit     = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
   // Reset must block a refill even if the FSM is still sitting in REQ this edge.
   assign fill_we = (state_q == REQ) && mem_ready_i && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         miss_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         miss_addr_q <= miss_addr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_we) begin
         data_q[miss_idx] <= mem_data_i;
         tag_q[miss_idx]  <= miss_tag;
      end
   end

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      miss_addr_d = miss_addr_q;
      // Invalidate is applied first so a coincident refill still lands valid.
      if (invalidate_i) valid_d = '0;
      unique case (state_q)
         IDLE: begin
            if (!hit) begin
               miss_addr_d = {pc_i[31:4], 4'b0000};
               state_d     = REQ;
            end
         end
         REQ: begin
            if (mem_ready_i) begin
               valid_d[miss_idx] = 1'b1;
               state_d           = FILL;
            end
         end
         FILL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      instr_o    = NOP;
      stall_o    = 1'b0;
      mem_req_o  = 1'b0;
      mem_addr_o = '0;
      if (!rst_i) begin
         stall_o = !hit;
         if (hit) instr_o = data_q[pc_idx][{pc_i[3:2], 5'b00000} +: 32];
         if (state_q == REQ) begin
            mem_req_o  = 1'b1;
            mem_addr_o = miss_addr_q;
         end
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, sweep, conflict, zero-wait refill,
// reset during refill and invalidate behaviour with hand-computed values.
module tb_icache_dm;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [31:0]   pc_i;
   logic          invalidate_i;
   logic [31:0]   instr_o;
   logic          stall_o;
   logic          mem_req_o;
   logic [31:0]   mem_addr_o;
   logic [127:0]  mem_data_i;
   logic          mem_ready_i;

   localparam logic [31:0]  NOP = 32'h0000_0013;
   localparam logic [127:0] D1  = {32'h00C0_0093, 32'h0080_0093, 32'h0040_0093, 32'h0010_0093};
   localparam logic [127:0] D2  = {32'hAAAA_0004, 32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001};
   localparam logic [127:0] D3  = {32'hBBBB_0004, 32'hBBBB_0003, 32'hBBBB_0002, 32'hBBBB_0001};
   localparam logic [127:0] DX  = {4{32'hDEAD_BEEF}};

   int npass = 0;
   int nchk  = 0;
   int stall_cnt, req_cnt;

   icache_dm #(.LINES(4), .LINE_WORDS(4), .NOP(32'h0000_0013)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pc_i         (pc_i),
      .invalidate_i (invalidate_i),
      .instr_o      (instr_o),
      .stall_o      (stall_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_i   (mem_data_i),
      .mem_ready_i  (mem_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b1; pc_i = 32'h1000; invalidate_i = 1'b0;
      mem_data_i = '0; mem_ready_i = 1'b0;
      tick(); tick();
      smp();
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_instr", instr_o, NOP);
      chk("rst_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);

      // Cold miss at 0x1000 with three wait cycles
      tick(); rst_i = 1'b0;
      smp();
      chk("cold_stall", {31'd0, stall_o}, 32'd1);
      chk("cold_req0", {31'd0, mem_req_o}, 32'd0);
      tick(); smp();
      chk("cold_req1", {31'd0, mem_req_o}, 32'd1);
      chk("cold_addr", mem_addr_o, 32'h1000);
      chk("cold_instr", instr_o, NOP);
      tick(); tick(); tick();
      smp();
      chk("cold_req_held", {31'd0, mem_req_o}, 32'd1);
      chk("cold_addr_held", mem_addr_o, 32'h1000);
      mem_ready_i = 1'b1; mem_data_i = D1;
      tick(); mem_ready_i = 1'b0; mem_data_i = DX;
      smp();
      chk("fill_req", {31'd0, mem_req_o}, 32'd0);
      chk("fill_stall", {31'd0, stall_o}, 32'd1);
      tick(); smp();
      chk("hit0_instr", instr_o, 32'h0010_0093);
      chk("hit0_stall", {31'd0, stall_o}, 32'd0);

      // Sweep the remaining words of the line
      tick(); pc_i = 32'h1004; smp();
      chk("sw4_instr", instr_o, 32'h0040_0093);
      chk("sw4_stall", {31'd0, stall_o | mem_req_o}, 32'd0);
      tick(); pc_i = 32'h1008; smp();
      chk("sw8_instr", instr_o, 32'h0080_0093);
      chk("sw8_stall", {31'd0, stall_o | mem_req_o}, 32'd0);
      tick(); pc_i = 32'h100C; smp();
      chk("swC_instr", instr_o, 32'h00C0_0093);
      chk("swC_stall", {31'd0, stall_o | mem_req_o}, 32'd0);

      // Conflict: 0x1040 maps to index 0 with a different tag
      tick(); pc_i = 32'h1040; smp();
      chk("cf_stall", {31'd0, stall_o}, 32'd1);
      tick(); smp();
      chk("cf_addr", mem_addr_o, 32'h1040);
      mem_ready_i = 1'b1; mem_data_i = D2;
      tick(); mem_ready_i = 1'b0;
      tick(); pc_i = 32'h1048; smp();
      chk("cf_hit", instr_o, 32'hAAAA_0003);
      chk("cf_hit_stall", {31'd0, stall_o}, 32'd0);

      // 0x1000 was evicted; refill it with memory ready tied high
      tick(); pc_i = 32'h1000; mem_ready_i = 1'b1; mem_data_i = D1;
      stall_cnt = 0; req_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         smp();
         if (stall_o) stall_cnt++;
         if (mem_req_o) req_cnt++;
         if (i < 5) tick();
      end
      chk("zw_stall_cycles", stall_cnt, 32'd3);
      chk("zw_req_cycles", req_cnt, 32'd1);
      chk("zw_hit", instr_o, 32'h0010_0093);
      tick(); mem_ready_i = 1'b0;

      // Reset while waiting in REQ
      pc_i = 32'h1010; smp();
      chk("rr_miss", {31'd0, stall_o}, 32'd1);
      tick(); smp();
      chk("rr_req", {31'd0, mem_req_o}, 32'd1);
      rst_i = 1'b1;
      tick(); smp();
      chk("rr_req_drop", {31'd0, mem_req_o}, 32'd0);
      mem_ready_i = 1'b1; mem_data_i = DX;
      tick(); mem_ready_i = 1'b0; rst_i = 1'b0; pc_i = 32'h1000;
      smp();
      chk("rr_1000_miss", {31'd0, stall_o}, 32'd1);
      chk("rr_1000_nop", instr_o, NOP);

      // Refill 0x1000 with an invalidate coinciding with the handshake
      tick(); smp();
      chk("inv_req_addr", mem_addr_o, 32'h1000);
      invalidate_i = 1'b1; mem_ready_i = 1'b1; mem_data_i = D1;
      tick(); invalidate_i = 1'b0; mem_ready_i = 1'b0;
      tick(); smp();
      chk("inv_req_hit", instr_o, 32'h0010_0093);
      chk("inv_req_stall", {31'd0, stall_o}, 32'd0);

      // Fill 0x1010 too
      tick(); pc_i = 32'h1010;
      tick(); mem_ready_i = 1'b1; mem_data_i = D3;
      tick(); mem_ready_i = 1'b0;
      tick(); pc_i = 32'h1014; smp();
      chk("h1010_instr", instr_o, 32'hBBBB_0002);

      // Invalidate in IDLE: same-cycle lookup still hits, next cycle both miss
      tick(); pc_i = 32'h1000; invalidate_i = 1'b1; smp();
      chk("inv_same_hit", instr_o, 32'h0010_0093);
      chk("inv_same_stall", {31'd0, stall_o}, 32'd0);
      tick(); invalidate_i = 1'b0; pc_i = 32'h1010; #1;
      chk("inv_1010_miss", {31'd0, stall_o}, 32'd1);
      pc_i = 32'h1000; smp();
      chk("inv_1000_miss", {31'd0, stall_o}, 32'd1);
      tick(); smp();
      chk("inv_1000_addr", mem_addr_o, 32'h1000);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
